mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Handshaked load/store engine between the multicycle control unit and the memory system.
// - Replaces the fixed single-cycle word access with a valid/ready bus that tolerates wait states.
// - Adds byte/half/word sizing, byte-lane steering, sign/zero extension, misalignment and timeout errors.
// - One request in flight; the control unit stalls on req_ready/resp_valid.
// PARAMETERS
// - ADDR_WIDTH   32  byte-address width of req_addr/bus_addr
// - TIMEOUT      16  max cycles bus_valid is held without bus_ready; 0 disables the timeout
// PORTS
// - clk        in   1            system clock, rising edge
// - rstn       in   1            asynchronous active-low reset
// - req_valid  in   1            access request from the control unit
// - req_ready  out  1            unit can accept a request (IDLE only)
// - req_we     in   1            1 = store, 0 = load
// - req_size   in   2            0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
// - req_unsigned in 1            loads only: 1 = zero-extend, 0 = sign-extend
// - req_addr   in   ADDR_WIDTH   byte address
// - req_wdata  in   32           store data, right-aligned
// - resp_valid out  1            one-cycle pulse: access complete
// - resp_err   out  1            qualifies resp_valid: misaligned or timed out
// - resp_rdata out  32           extended load data; 0 on stores and on errors
// - bus_valid  out  1            memory request
// - bus_ready  in   1            memory accepts/completes the request this cycle
// - bus_we     out  1            memory write enable
// - bus_strb   out  4            byte-lane write strobes; 4'b0000 on loads
// - bus_addr   out  ADDR_WIDTH   word-aligned address ({req_addr[ADDR_WIDTH-1:2],2'b00})
// - bus_wdata  out  32           lane-steered store data
// - bus_rdata  in   32           read data, sampled when bus_valid && bus_ready
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; all outputs 0 except req_ready=1; timeout counter 0.
// - FSM states and transitions:
//   - IDLE: req_ready=1.
//     - req_valid with aligned addr -> BUS; latch we/size/unsigned/addr/wdata.
//     - req_valid with misaligned addr -> ERR.
//   - BUS: bus_* driven from registers and stable until the handshake.
//     - bus_ready -> RESP; capture bus_rdata.
//     - counter == TIMEOUT-1 with TIMEOUT != 0 -> ERR; bus_valid drops the next cycle.
//   - RESP: resp_valid=1, resp_err=0 -> IDLE.
//   - ERR: resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE; no bus transaction is issued for misalignment.
// - Alignment: half requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
// - Latency: accept at cycle N; bus_valid at N+1; bus_ready at N+1+k; resp_valid at N+2+k.
//   - Minimum request-to-response latency is 2 cycles.
//   - Back-to-back requests are accepted in the cycle after resp_valid.
// - Lanes (o = addr[1:0]):
//   - byte: strb = 4'b0001 << o; wdata = {4{wdata[7:0]}}.
//   - half: strb = 4'b0011 << o; wdata = {2{wdata[15:0]}}.
//   - word: strb = 4'hF.
// - Loads:
//   - byte: rdata = bus_rdata[8*o +: 8], extended to 32 bits.
//   - half: rdata = bus_rdata[8*o +: 16], extended to 32 bits.
//   - word: rdata passed through unchanged.
// - Timeout counter: cleared on entry to BUS; increments each BUS cycle without bus_ready.
// - If bus_ready and timeout coincide, bus_ready wins (RESP).
// - req_valid outside IDLE is ignored; the requester holds it until req_ready.
// - Reset mid-BUS: bus_valid falls asynchronously; the memory side must tolerate an abandoned request.
// STRUCTURE
// - cpu_pkg holds:
//   - size encodings SIZE_B/SIZE_H/SIZE_W;
//   - mau_state_t {IDLE,BUS,RESP,ERR};
//   - the lane-steering helper function prototypes.
// - One combinational sub-module, mem_lane_align, computes:
//   - the misalignment flag;
//   - bus_strb and steered bus_wdata;
//   - extract/extend of load data.
// - The FSM, request registers and timeout counter stay in mem_access_unit.
// TESTING
// - Store word, addr 0x100, data 0xDEADBEEF, bus_ready held 1:
//   - bus_strb=F, bus_wdata=0xDEADBEEF, bus_addr=0x100;
//   - resp_valid 2 cycles after accept; resp_err=0.
// - Signed byte load, addr 0x103, bus_rdata=0x80FF_0000:
//   - resp_rdata=0xFFFFFF80.
//   - Same access with req_unsigned=1 -> 0x00000080.
// - Store half, addr 0x102, data 0x1234ABCD:
//   - bus_strb=4'b1100, bus_wdata=0xABCDABCD.
//   - Half load at 0x102 with bus_rdata=0x7FFF0000 -> 0x00007FFF.
// - Misaligned word store, addr 0x101:
//   - bus_valid never rises;
//   - resp_valid+resp_err 1 cycle after accept, resp_rdata=0.
// - Wait states (bus_ready low 3 cycles): bus signals stable throughout; resp_valid 5 cycles after accept.
//   - TIMEOUT=4 with bus_ready never high: resp_err after 4 BUS cycles, then bus_valid=0.
// - Reset asserted mid-BUS:
//   - bus_valid=0 and req_ready=1 immediately;
//   - the next request after release completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and byte-lane helpers for the memory access path.
package cpu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } mau_state_t;

    // Reserved size 3 falls into the default (word) arm everywhere below.
    function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            default: mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_B:  strb = 4'b0001 << off;
            SIZE_H:  strb = 4'b0011 << off;
            default: strb = 4'hF;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] steered;
        case (size)
            SIZE_B:  steered = {4{wdata[7:0]}};
            SIZE_H:  steered = {2{wdata[15:0]}};
            default: steered = wdata;
        endcase
        return steered;
    endfunction

    function automatic logic [31:0] lane_load(input logic [1:0] size, input logic [1:0] off,
                                              input logic is_unsigned, input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = rdata >> {off, 3'b000};
        case (size)
            SIZE_B:  ext = is_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  ext = is_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = rdata;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: alignment check, store strobes/data, load extract/extend.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned_c,
    output logic [3:0]  strb_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    always_comb begin
        misaligned_c = lane_misaligned(size, addr_lo);
        strb_c       = lane_strb(size, addr_lo);
        wdata_c      = lane_wdata(size, wdata);
        rdata_c      = lane_load(size, addr_lo, is_unsigned, rdata);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked load/store engine: one request in flight, byte/half/word sizing,
// wait-state tolerant bus with misalignment and timeout errors.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [3:0]            bus_strb,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata
);

    localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic        TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mau_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic                  uns_q, uns_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_we_q, bus_we_d;
    logic [3:0]            bus_strb_q, bus_strb_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;

    logic        in_idle;
    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic        mis_c;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [31:0] rdata_c;

    // In IDLE the lane logic checks the incoming request; otherwise it decodes the latched one.
    assign in_idle = (state_q == IDLE);
    assign al_size = in_idle ? req_size : size_q;
    assign al_off  = in_idle ? req_addr[1:0] : off_q;

    mem_lane_align u_align (
        .size         (al_size),
        .addr_lo      (al_off),
        .is_unsigned  (uns_q),
        .wdata        (req_wdata),
        .rdata        (bus_rdata),
        .misaligned_c (mis_c),
        .strb_c       (strb_c),
        .wdata_c      (wdata_c),
        .rdata_c      (rdata_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        bus_we_d     = bus_we_q;
        bus_strb_d   = bus_strb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (mis_c) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        we_d        = req_we;
                        size_d      = req_size;
                        off_d       = req_addr[1:0];
                        uns_d       = req_unsigned;
                        bus_we_d    = req_we;
                        bus_strb_d  = req_we ? strb_c : 4'b0000;
                        bus_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_wdata_d = req_we ? wdata_c : 32'd0;
                    end
                end
            end
            BUS: begin
                if (bus_ready) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : rdata_c;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d      = ERR;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        bus_valid_d = (state_d == BUS);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_B;
            off_q        <= 2'd0;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_strb_q   <= 4'b0000;
            bus_addr_q   <= '0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_strb_q   <= bus_strb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_strb   = bus_strb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): lanes, extension, wait states, errors, reset.
module tb_mem_access_unit;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks;
    int errors;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_strb     (bus_strb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns #1 after the accepting edge.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid = 1'b0;
    endtask

    // One-wait-free access completing in the cycle after bus_valid rises.
    task automatic quick(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
        bus_ready = 1'b1;
        bus_rdata = rd;
        send(we, size, uns, addr, wdata);
        chk({tag, "_bus_valid"}, 32'(bus_valid), 32'd1);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_bus_we"}, 32'(bus_we), 32'(we));
        chk({tag, "_bus_strb"}, 32'(bus_strb), 32'(exp_strb));
        chk({tag, "_bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        if (we) chk({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
        chk({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
        step();
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_bus_drop"}, 32'(bus_valid), 32'd0);
        step();
        chk({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(req_ready), 32'd1);
    endtask

    task automatic misalign(input string tag, input logic we, input logic [1:0] size,
                            input logic [31:0] addr);
        bus_ready = 1'b1;
        send(we, size, 1'b0, addr, 32'hFFFF_FFFF);
        chk({tag, "_no_bus"}, 32'(bus_valid), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd1);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        step();
        chk({tag, "_no_bus_after"}, 32'(bus_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        bus_ready    = 1'b0;
        bus_rdata    = 32'd0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_bus_strb", 32'(bus_strb), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        rstn = 1'b1;
        step();

        quick("sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0,
              4'hF, 32'hDEAD_BEEF, 32'h0);
        quick("lb_s", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000,
              4'h0, 32'h0, 32'hFFFF_FF80);
        quick("lb_u", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000,
              4'h0, 32'h0, 32'h0000_0080);
        quick("sh", 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 32'h0,
              4'b1100, 32'hABCD_ABCD, 32'h0);
        quick("lh_pos", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h7FFF_0000,
              4'h0, 32'h0, 32'h0000_7FFF);
        quick("lh_neg", 1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h1234_8001,
              4'h0, 32'h0, 32'hFFFF_8001);
        quick("sb", 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_005A, 32'h0,
              4'b0010, 32'h5A5A_5A5A, 32'h0);
        quick("lw_rsv", 1'b0, 2'd3, 1'b0, 32'h10C, 32'h0, 32'h8765_4321,
              4'h0, 32'h0, 32'h8765_4321);

        misalign("mis_sw", 1'b1, 2'd2, 32'h101);
        misalign("mis_lh", 1'b0, 2'd1, 32'h103);

        // Three wait states; ready arrives on the last cycle before timeout and must win.
        bus_ready = 1'b0;
        bus_rdata = 32'hCAFE_F00D;
        send(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            chk("ws_bus_valid", 32'(bus_valid), 32'd1);
            chk("ws_bus_addr", bus_addr, 32'h200);
            chk("ws_bus_we", 32'(bus_we), 32'd0);
            chk("ws_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        chk("ws_bus_valid_last", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        step();
        chk("ws_resp_valid", 32'(resp_valid), 32'd1);
        chk("ws_resp_err", 32'(resp_err), 32'd0);
        chk("ws_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        step();

        // Timeout: bus_ready never rises.
        bus_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            chk("to_bus_valid", 32'(bus_valid), 32'd1);
            chk("to_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_resp_err", 32'(resp_err), 32'd1);
        chk("to_resp_rdata", resp_rdata, 32'd0);
        chk("to_bus_drop", 32'(bus_valid), 32'd0);
        step();
        chk("to_ready_again", 32'(req_ready), 32'd1);

        // Asynchronous reset while a request is on the bus.
        send(1'b1, 2'd2, 1'b0, 32'h400, 32'h1111_2222);
        chk("rb_bus_valid", 32'(bus_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rb_bus_valid_async", 32'(bus_valid), 32'd0);
        chk("rb_req_ready_async", 32'(req_ready), 32'd1);
        #2;
        rstn = 1'b1;
        step();
        quick("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h1122_3344,
              4'h0, 32'h0, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
